det4_host_ctrl: RTL and testbench

Host-side initiator for the 4x4 determinant unit. It accepts 16 signed 8-bit matrix elements as a valid/ready byte stream in row-major order and holds them as a stable parallel bus. It then issues a one-cycle start, waits for done, captures the 16-bit determinant, and returns it on a valid/ready result port. It sits between the coprocessor's command/data path and the determinant datapath.

---
 rtl/det4_host_ctrl.sv | 137 +++++++++++++
 tb/tb_det4_host_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/det4_host_ctrl.sv
// rtl/det4_host_ctrl.sv - host initiator that streams a 4x4 matrix to the determinant unit and returns its result
// Optional WAIT timeout abort is compiled in with `define DET_TIMEOUT_EN.
module det4_host_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    output logic         in_ready,
    output logic [127:0] mat_out,
    output logic         det_start,
    input  logic         det_done,
    input  logic [15:0]  det_result,
    output logic         res_valid,
    output logic [15:0]  res_data,
    output logic         res_err,
    input  logic         res_ready
);

    typedef enum logic [1:0] {S_LOAD, S_START, S_WAIT, S_OUT} state_t;

    state_t         state_q, state_d;
    logic [3:0]     idx_q, idx_d;
    logic [127:0]   mat_q, mat_d;
    logic [15:0]    res_data_q, res_data_d;
    logic           res_valid_q, res_valid_d;
    logic           accept;
    logic           timeout_hit;

    assign accept = (state_q == S_LOAD) && in_valid;

`ifdef DET_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       res_err_q, res_err_d;

    // The counter holds the number of WAIT cycles already completed, so the
    // TIMEOUT-th WAIT cycle is the one where it equals TIMEOUT-1.
    assign timeout_hit = (state_q == S_WAIT) && !det_done && (cnt_q == 8'(TIMEOUT - 1));
    assign cnt_d       = (state_q == S_WAIT) ? cnt_q + 8'd1 : 8'd0;
    assign res_err     = res_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= 8'd0;
            res_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            res_err_q <= res_err_d;
        end
    end

    always_comb begin
        res_err_d = res_err_q;
        if (state_q == S_WAIT) begin
            if (det_done)
                res_err_d = 1'b0;
            else if (timeout_hit)
                res_err_d = 1'b1;
        end else if (state_q == S_OUT && res_ready) begin
            res_err_d = 1'b0;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^8'(TIMEOUT);
    assign timeout_hit    = 1'b0;
    assign res_err        = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= S_LOAD;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LOAD:  if (accept && idx_q == 4'd15) state_d = S_START;
            S_START: state_d = S_WAIT;
            S_WAIT:  if (det_done || timeout_hit) state_d = S_OUT;
            S_OUT:   if (res_ready) state_d = S_LOAD;
            default: state_d = S_LOAD;
        endcase
    end

    always_comb begin
        in_ready    = (state_q == S_LOAD) && !rst;
        det_start   = (state_q == S_START);
        idx_d       = idx_q;
        mat_d       = mat_q;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;
        case (state_q)
            S_LOAD: begin
                if (accept) begin
                    mat_d[{idx_q, 3'b000} +: 8] = in_data;
                    idx_d = idx_q + 4'd1;
                end
            end
            S_WAIT: begin
                if (det_done) begin
                    res_data_d  = det_result;
                    res_valid_d = 1'b1;
                end else if (timeout_hit) begin
                    res_data_d  = 16'h8000;
                    res_valid_d = 1'b1;
                end
            end
            S_OUT: begin
                if (res_ready) res_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q       <= 4'd0;
            mat_q       <= 128'd0;
            res_data_q  <= 16'd0;
            res_valid_q <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            mat_q       <= mat_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign mat_out   = mat_q;
    assign res_data  = res_data_q;
    assign res_valid = res_valid_q;

endmodule

// File: tb/tb_det4_host_ctrl.sv
// tb/tb_det4_host_ctrl.sv - directed self-checking bench for det4_host_ctrl
module tb_det4_host_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [7:0]   in_data = 8'd0;
    logic         in_ready;
    logic [127:0] mat_out;
    logic         det_start;
    logic         det_done = 1'b0;
    logic [15:0]  det_result = 16'd0;
    logic         res_valid;
    logic [15:0]  res_data;
    logic         res_err;
    logic         res_ready = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int n_start = 0;

    det4_host_ctrl #(.TIMEOUT(10)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mat_out(mat_out), .det_start(det_start),
        .det_done(det_done), .det_result(det_result),
        .res_valid(res_valid), .res_data(res_data), .res_err(res_err),
        .res_ready(res_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (det_start) n_start <= n_start + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] pack(input logic [7:0] b [16]);
        logic [127:0] m;
        for (int k = 0; k < 16; k++) m[8*k +: 8] = b[k];
        return m;
    endfunction

    // Reference determinant used by the stub; expansion along the first row.
    function automatic logic [15:0] det4(input logic [127:0] m);
        int a [4][4];
        int cs [3];
        int j, d3, det;
        for (int k = 0; k < 16; k++) a[k/4][k%4] = int'($signed(m[8*k +: 8]));
        det = 0;
        for (int c = 0; c < 4; c++) begin
            j = 0;
            for (int cc = 0; cc < 4; cc++) if (cc != c) begin cs[j] = cc; j++; end
            d3 = a[1][cs[0]] * (a[2][cs[1]] * a[3][cs[2]] - a[2][cs[2]] * a[3][cs[1]])
               - a[1][cs[1]] * (a[2][cs[0]] * a[3][cs[2]] - a[2][cs[2]] * a[3][cs[0]])
               + a[1][cs[2]] * (a[2][cs[0]] * a[3][cs[1]] - a[2][cs[1]] * a[3][cs[0]]);
            det += ((c % 2) != 0 ? -1 : 1) * a[0][c] * d3;
        end
        return 16'(det);
    endfunction

    // Streams 16 bytes; returns at one cycle past the edge accepting byte 15.
    task automatic send(input logic [7:0] b [16], input bit gaps);
        int n;
        for (int k = 0; k < 16; k++) begin
            in_data  = b[k];
            in_valid = 1'b1;
            n = 0;
            while (!in_ready && n < 50) begin tick; n++; end
            if (n >= 50) check("in_ready_timeout", 0, 1);
            tick;
            in_valid = 1'b0;
            if (k < 15) check("no_start_early", det_start, 0);
            if (gaps && k < 15) tick;
        end
    endtask

    task automatic run_matrix(input string tag, input logic [7:0] b [16], input bit gaps,
                              input logic [127:0] exp_mat, input logic [15:0] exp_det,
                              input int hold);
        int s0;
        s0 = n_start;
        send(b, gaps);
        check({tag, "_start"}, det_start, 1);
        check({tag, "_busy"}, in_ready, 0);
        check({tag, "_mat"}, mat_out, exp_mat);
        tick;
        check({tag, "_start_one"}, det_start, 0);
        tick;
        check({tag, "_wait"}, res_valid, 0);
        det_result = det4(mat_out);
        det_done   = 1'b1;
        if (hold == 0) res_ready = 1'b1;
        tick;
        det_done   = 1'b0;
        det_result = 16'd0;
        check({tag, "_valid"}, res_valid, 1);
        check({tag, "_data"}, res_data, exp_det);
        check({tag, "_err"}, res_err, 0);
        check({tag, "_pulses"}, n_start - s0, 1);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h55;
            if (i == 2) begin det_done = 1'b1; det_result = 16'h7777; end
            tick;
            det_done = 1'b0;
            check({tag, "_hold_valid"}, res_valid, 1);
            check({tag, "_hold_data"}, res_data, exp_det);
            check({tag, "_hold_rdy"}, in_ready, 0);
        end
        in_valid  = 1'b0;
        res_ready = 1'b1;
        tick;
        res_ready = 1'b0;
        check({tag, "_consumed"}, res_valid, 0);
        check({tag, "_reload"}, in_ready, 1);
    endtask

    logic [7:0] m_id   [16] = '{8'd1,8'd0,8'd0,8'd0, 8'd0,8'd1,8'd0,8'd0, 8'd0,8'd0,8'd1,8'd0, 8'd0,8'd0,8'd0,8'd1};
    logic [7:0] m_diag [16] = '{8'd2,8'd0,8'd0,8'd0, 8'd0,8'd3,8'd0,8'd0, 8'd0,8'd0,8'd1,8'd0, 8'd0,8'd0,8'd0,8'hFF};
    logic [7:0] m_tri  [16] = '{8'd2,8'd5,8'hFD,8'd7, 8'd0,8'hFF,8'd4,8'd2, 8'd0,8'd0,8'd3,8'd9, 8'd0,8'd0,8'd0,8'd4};

    initial begin
        int n;
        tick; tick;
        check("rst_in_ready", in_ready, 0);
        check("rst_mat", mat_out, 0);
        check("rst_valid", res_valid, 0);
        check("rst_start", det_start, 0);
        rst = 1'b0;
        tick;
        check("idle_in_ready", in_ready, 1);
        check("idle_data", res_data, 0);
        check("idle_err", res_err, 0);

        run_matrix("ident", m_id, 1'b0, 128'h01000000_00010000_00000100_00000001, 16'd1, 0);
        run_matrix("diag", m_diag, 1'b1, pack(m_diag), 16'hFFFA, 5);
        run_matrix("tri", m_tri, 1'b0, pack(m_tri), 16'hFFE8, 1);

        // Reset while waiting for the determinant unit.
        send(m_diag, 1'b0);
        tick;
        rst = 1'b1;
        #1;
        check("rstw_in_ready", in_ready, 0);
        tick;
        check("rstw_mat", mat_out, 0);
        check("rstw_valid", res_valid, 0);
        check("rstw_start", det_start, 0);
        rst        = 1'b0;
        det_done   = 1'b1;
        det_result = 16'h1234;
        tick;
        det_done   = 1'b0;
        check("rstw_late_done", res_valid, 0);
        check("rstw_in_ready1", in_ready, 1);
        tick;
        check("rstw_still_idle", res_valid, 0);
        run_matrix("after_rst", m_tri, 1'b1, pack(m_tri), 16'hFFE8, 0);

`ifdef DET_TIMEOUT_EN
        send(m_id, 1'b0);
        tick;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (res_valid) n++;
            tick;
        end
        check("tmo_not_early", n, 0);
        check("tmo_valid", res_valid, 1);
        check("tmo_data", res_data, 16'h8000);
        check("tmo_err", res_err, 1);
        res_ready = 1'b1;
        tick;
        res_ready = 1'b0;
        check("tmo_consumed", res_valid, 0);

        send(m_id, 1'b0);
        tick;
        for (int i = 0; i < 9; i++) tick;
        det_done   = 1'b1;
        det_result = 16'h0007;
        tick;
        det_done   = 1'b0;
        check("tmo_race_valid", res_valid, 1);
        check("tmo_race_data", res_data, 16'h0007);
        check("tmo_race_err", res_err, 0);
        res_ready = 1'b1;
        tick;
        res_ready = 1'b0;
`else
        n = 0;
`endif
        check("final_idle", in_ready, 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
